// File: rtl/freq_div_frac_if.sv
// Bus bundle for the fractional clock divider: run control, divisor programming and divided outputs.
// cfg_load is a one-cycle request with no back-pressure: a legal load is answered by one cfg_ack pulse
// when it takes effect (a later load may supersede it), an illegal load by one cfg_err pulse a cycle later.
interface freq_div_frac_if #(
  parameter int INT_W  = 8,
  parameter int FRAC_W = 8
);
  logic              en;
  logic [INT_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_num;
  logic [FRAC_W-1:0] div_den;
  logic              cfg_load;
  logic              cfg_ack;
  logic              cfg_err;
  logic              clk_out;
  logic              tick;
  logic [1:0]        dbg_state;

  modport master (
    output en, div_int, div_num, div_den, cfg_load,
    input  cfg_ack, cfg_err, clk_out, tick, dbg_state
  );

  modport slave (
    input  en, div_int, div_num, div_den, cfg_load,
    output cfg_ack, cfg_err, clk_out, tick, dbg_state
  );
endinterface

// File: rtl/freq_div_frac.sv
// Fractional clock divider: first-order accumulator picks div_int or div_int+1 cycles per period,
// each period is high for floor(P/2) cycles then low for the rest; outputs trail the FSM by one register.
module freq_div_frac #(
  parameter int INT_W   = 8,
  parameter int FRAC_W  = 8,
  parameter int DEF_INT = 2
) (
  input logic           clk,
  input logic           rst,
  freq_div_frac_if.slave bus
);

  localparam int CNT_W = INT_W + 1;
  localparam int ACC_W = FRAC_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  lo_q, lo_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [INT_W-1:0]  act_int_q, act_int_d, shd_int_q, shd_int_d;
  logic [FRAC_W-1:0] act_num_q, act_num_d, shd_num_q, shd_num_d;
  logic [FRAC_W-1:0] act_den_q, act_den_d, shd_den_q, shd_den_d;
  logic              pend_q, pend_d;
  logic              start_ack_q, start_ack_d;
  logic              clk_out_q, clk_out_d;
  logic              tick_q, tick_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;

  logic              cfg_legal, load_ok, expire, start, idle_apply, apply, roll;
  logic [INT_W-1:0]  use_int;
  logic [FRAC_W-1:0] use_num, use_den;
  logic [ACC_W-1:0]  acc_base, acc_sum;
  logic [CNT_W-1:0]  period, hi_len, lo_len;

  always_comb begin
    cfg_legal  = (bus.div_int >= INT_W'(2)) && (bus.div_den != '0) && (bus.div_num < bus.div_den);
    load_ok    = bus.cfg_load && cfg_legal;
    expire     = (cnt_q == CNT_W'(1));
    start      = bus.en && ((state_q == S_IDLE) || ((state_q == S_LOW) && expire));
    idle_apply = pend_q && (state_q == S_IDLE) && !bus.en;
    apply      = pend_q && (start || idle_apply);

    // A config applied at a period start governs that very period, with a fresh accumulator.
    use_int  = apply ? shd_int_q : act_int_q;
    use_num  = apply ? shd_num_q : act_num_q;
    use_den  = apply ? shd_den_q : act_den_q;
    acc_base = apply ? '0 : acc_q;
    acc_sum  = acc_base + {1'b0, use_num};
    roll     = (acc_sum >= {1'b0, use_den});
    period   = {1'b0, use_int} + {{INT_W{1'b0}}, roll};
    hi_len   = period >> 1;
    lo_len   = period - hi_len;

    state_d     = state_q;
    cnt_d       = cnt_q;
    lo_d        = lo_q;
    acc_d       = acc_q;
    act_int_d   = act_int_q;
    act_num_d   = act_num_q;
    act_den_d   = act_den_q;
    shd_int_d   = shd_int_q;
    shd_num_d   = shd_num_q;
    shd_den_d   = shd_den_q;
    pend_d      = pend_q;
    start_ack_d = 1'b0;

    case (state_q)
      S_HIGH: begin
        if (expire) begin
          state_d = S_LOW;
          cnt_d   = lo_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_LOW: begin
        if (expire) state_d = S_IDLE;
        else        cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase

    if (start) begin
      state_d = S_HIGH;
      cnt_d   = hi_len;
      lo_d    = lo_len;
      acc_d   = roll ? (acc_sum - {1'b0, use_den}) : acc_sum;
    end

    if (apply) begin
      act_int_d   = shd_int_q;
      act_num_d   = shd_num_q;
      act_den_d   = shd_den_q;
      pend_d      = 1'b0;
      start_ack_d = start;
      if (!start) acc_d = '0;
    end

    // A load in the same cycle as a start only reaches the shadow; it waits for the next start.
    if (load_ok) begin
      shd_int_d = bus.div_int;
      shd_num_d = bus.div_num;
      shd_den_d = bus.div_den;
      pend_d    = 1'b1;
    end

    clk_out_d = (state_q == S_HIGH);
    tick_d    = clk_out_d && !clk_out_q;
    ack_d     = start_ack_q || idle_apply;
    err_d     = bus.cfg_load && !cfg_legal;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      lo_q        <= '0;
      acc_q       <= '0;
      act_int_q   <= INT_W'(DEF_INT);
      act_num_q   <= '0;
      act_den_q   <= FRAC_W'(1);
      shd_int_q   <= INT_W'(DEF_INT);
      shd_num_q   <= '0;
      shd_den_q   <= FRAC_W'(1);
      pend_q      <= 1'b0;
      start_ack_q <= 1'b0;
      clk_out_q   <= 1'b0;
      tick_q      <= 1'b0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lo_q        <= lo_d;
      acc_q       <= acc_d;
      act_int_q   <= act_int_d;
      act_num_q   <= act_num_d;
      act_den_q   <= act_den_d;
      shd_int_q   <= shd_int_d;
      shd_num_q   <= shd_num_d;
      shd_den_q   <= shd_den_d;
      pend_q      <= pend_d;
      start_ack_q <= start_ack_d;
      clk_out_q   <= clk_out_d;
      tick_q      <= tick_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
    end
  end

  assign bus.clk_out   = clk_out_q;
  assign bus.tick      = tick_q;
  assign bus.cfg_ack   = ack_q;
  assign bus.cfg_err   = err_q;
  assign bus.dbg_state = state_q;

endmodule
